instruction_fetch_stage: RTL and testbench

Owns the program counter and the fetch/decode (IF/ID) pipeline register. It issues one instruction-memory read per PC and feeds the decode stage. It obeys the hazard unit's `load_enable` (stall) and `flush` (squash plus redirect) signals. It tolerates multi-cycle memory by holding a fetched word while stalled and discarding responses made stale by a redirect.

---
 rtl/instruction_fetch_stage_pkg.sv | 14 +
 rtl/instruction_fetch_stage_if.sv | 24 ++
 rtl/instruction_fetch_stage_if_id_register.sv | 36 +++
 rtl/instruction_fetch_stage.sv | 118 +++++++++++
 tb/tb_instruction_fetch_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the fetch stage.
// FSM state encoding, PC step and default bubble word.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP
  } state_t;

  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory read bus.
// master: req/addr out, ack/rdata in; slave is the mirror.
interface instruction_fetch_stage_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: instruction, pc+4 and valid.
// Ports: clk, rst (async low), en, flush, bubble, instr_in, pc_plus4_in.
module if_id_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush || (en && bubble)) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (en) begin
      instr    <= instr_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, stall buffer, stale-response FSM, IF/ID register.
// Ports: clk, rst, load_enable, flush, redirect_pc, imem bus, fd_*, pc.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_enable,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  instruction_fetch_stage_if.master imem,
  output logic [31:0] fd_instruction,
  output logic [31:0] fd_pc_plus4,
  output logic        fd_valid,
  output logic [31:0] pc
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc_nx;
  logic [31:0] buf_q;
  logic [31:0] buf_nx;
  logic [31:0] drop_q;
  logic [31:0] drop_nx;
  logic        ld;
  logic        bub;
  logic        sq;
  logic [31:0] word;

  // Request is gated by reset so nothing leaves while in reset.
  assign imem.req  = rst & (state != HOLD);
  assign imem.addr = (state == DROP) ? drop_q : pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      buf_q  <= '0;
      drop_q <= '0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      buf_q  <= buf_nx;
      drop_q <= drop_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    buf_nx   = buf_q;
    drop_nx  = drop_q;
    ld       = 1'b0;
    bub      = 1'b0;
    sq       = 1'b0;
    word     = buf_q;
    if (flush) begin
      sq     = 1'b1;
      pc_nx  = redirect_pc & ~32'h3;
      buf_nx = '0;
      // An unacked request stays on the bus at its old address.
      if (state != HOLD && !imem.ack) begin
        state_nx = DROP;
        if (state == FETCH) drop_nx = pc;
      end else begin
        state_nx = FETCH;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (imem.ack && load_enable) begin
            ld    = 1'b1;
            word  = imem.rdata;
            pc_nx = pc + PC_STEP;
          end else if (imem.ack) begin
            buf_nx   = imem.rdata;
            state_nx = HOLD;
          end else if (load_enable) begin
            ld  = 1'b1;
            bub = 1'b1;
          end
        end
        HOLD: begin
          if (load_enable) begin
            ld       = 1'b1;
            pc_nx    = pc + PC_STEP;
            state_nx = FETCH;
          end
        end
        DROP: begin
          ld  = load_enable;
          bub = 1'b1;
          if (imem.ack) state_nx = FETCH;
        end
        default: state_nx = FETCH;
      endcase
    end
  end

  if_id_register #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .en         (ld),
    .flush      (sq),
    .bubble     (bub),
    .instr_in   (word),
    .pc_plus4_in(pc + PC_STEP),
    .instr      (fd_instruction),
    .pc_plus4   (fd_pc_plus4),
    .valid      (fd_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage.
// Memory returns its address as data with programmable latency.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_enable;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] fd_instruction;
  logic [31:0] fd_pc_plus4;
  logic        fd_valid;
  logic [31:0] pc;

  int errors = 0;
  int checks = 0;
  int lat    = 0;
  int cnt;
  int n10    = 0;
  bit seen20 = 0;
  bit seen40 = 0;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage u_dut (
    .clk           (clk),
    .rst           (rst),
    .load_enable   (load_enable),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .imem          (bus.master),
    .fd_instruction(fd_instruction),
    .fd_pc_plus4   (fd_pc_plus4),
    .fd_valid      (fd_valid),
    .pc            (pc)
  );

  always #5 clk = ~clk;

  assign bus.ack   = bus.req && (cnt == lat);
  assign bus.rdata = bus.ack ? bus.addr : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst) begin
    if (!rst)                    cnt <= 0;
    else if (!bus.req || bus.ack) cnt <= 0;
    else                          cnt <= cnt + 1;
  end

  always @(negedge clk) begin
    if (bus.ack && bus.addr == 32'h10) n10++;
    if (fd_valid && fd_instruction == 32'h20) seen20 = 1;
    if (fd_valid && fd_instruction == 32'h40) seen40 = 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fd(input string tag,
                    input logic [31:0] ins,
                    input logic        v);
    chk({tag, ".instr"}, fd_instruction, ins);
    chk({tag, ".valid"}, {31'b0, fd_valid}, {31'b0, v});
  endtask

  initial begin
    rst         = 1'b0;
    load_enable = 1'b1;
    flush       = 1'b0;
    redirect_pc = '0;
    repeat (2) tick();
    chk("rst.req", {31'b0, bus.req}, 32'h0);
    chk("rst.pc", pc, 32'h0);
    fd("rst", 32'h0, 1'b0);
    chk("rst.pc4", fd_pc_plus4, 32'h0);
    #3 rst = 1'b1;

    tick();
    fd("e1", 32'h0, 1'b1);
    chk("e1.pc4", fd_pc_plus4, 32'h4);
    chk("e1.pc", pc, 32'h4);
    tick();
    fd("e2", 32'h4, 1'b1);
    tick();
    fd("e3", 32'h8, 1'b1);
    tick();
    fd("e4", 32'hC, 1'b1);
    chk("e4.pc", pc, 32'h10);
    chk("e4.addr", bus.addr, 32'h10);

    load_enable = 1'b0;
    tick();
    fd("st1", 32'hC, 1'b1);
    chk("st1.req", {31'b0, bus.req}, 32'h0);
    chk("st1.pc", pc, 32'h10);
    tick();
    tick();
    fd("st3", 32'hC, 1'b1);
    load_enable = 1'b1;
    tick();
    fd("rel", 32'h10, 1'b1);
    chk("rel.pc4", fd_pc_plus4, 32'h14);
    chk("rel.pc", pc, 32'h14);
    tick();
    chk("rel.n10", n10, 1);
    fd("r14", 32'h14, 1'b1);
    tick();
    tick();
    fd("r1c", 32'h1C, 1'b1);
    chk("r1c.addr", bus.addr, 32'h20);

    flush       = 1'b1;
    redirect_pc = 32'h101;
    tick();
    flush = 1'b0;
    fd("fl", 32'h0, 1'b0);
    chk("fl.pc4", fd_pc_plus4, 32'h0);
    chk("fl.pc", pc, 32'h100);
    tick();
    fd("tgt", 32'h100, 1'b1);
    chk("tgt.seen20", {31'b0, seen20}, 32'h0);

    flush       = 1'b1;
    redirect_pc = 32'h40;
    tick();
    flush = 1'b0;
    lat   = 2;
    chk("s0.addr", bus.addr, 32'h40);
    tick();
    fd("s1", 32'h0, 1'b0);
    flush       = 1'b1;
    redirect_pc = 32'h200;
    tick();
    flush = 1'b0;
    chk("drop.addr", bus.addr, 32'h40);
    chk("drop.req", {31'b0, bus.req}, 32'h1);
    chk("drop.pc", pc, 32'h200);
    tick();
    chk("d1.addr", bus.addr, 32'h200);
    fd("d1", 32'h0, 1'b0);
    tick();
    tick();
    fd("d3", 32'h0, 1'b0);
    tick();
    fd("d4", 32'h200, 1'b1);
    chk("d4.pc", pc, 32'h204);
    chk("d4.seen40", {31'b0, seen40}, 32'h0);

    lat         = 0;
    load_enable = 1'b0;
    flush       = 1'b1;
    redirect_pc = 32'h300;
    tick();
    flush       = 1'b0;
    load_enable = 1'b1;
    fd("fs", 32'h0, 1'b0);
    chk("fs.pc", pc, 32'h300);
    tick();
    fd("fs2", 32'h300, 1'b1);

    lat         = 3;
    flush       = 1'b1;
    redirect_pc = 32'h400;
    tick();
    flush = 1'b0;
    chk("ar.addr", bus.addr, 32'h304);
    #3 rst = 1'b0;
    #1;
    chk("ar.req", {31'b0, bus.req}, 32'h0);
    chk("ar.pc", pc, 32'h0);
    chk("ar.pc4", fd_pc_plus4, 32'h0);
    fd("ar", 32'h0, 1'b0);
    lat = 0;
    tick();
    #3 rst = 1'b1;
    tick();
    fd("rs1", 32'h0, 1'b1);
    chk("rs1.pc", pc, 32'h4);
    tick();
    fd("rs2", 32'h4, 1'b1);

    flush       = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    chk("wr.pc", pc, 32'hFFFF_FFFC);
    tick();
    fd("wr", 32'hFFFF_FFFC, 1'b1);
    chk("wr.pc4", fd_pc_plus4, 32'h0);
    chk("wr.pcn", pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
